gray_step_counter: RTL and testbench
====================================

// Module: gray_step_counter
// PURPOSE
//  Up/down Gray-code counter; upstream source of the 4-bit gray word consumed by the
//  Gray-to-binary decode stage. Produces a registered Gray value that changes exactly
//  one bit per step. Steps are paced by an internal enable prescaler. Supports
//  parallel load, wrap or saturate at the ends, and a terminal-count pulse.
// PARAMETERS
//  WIDTH     4  counter / gray word width (>=2)
//  TICK_DIV  1  number of en-high cycles per step (>=1; 1 = step on every en cycle)
//  WRAP      1  1: wrap max<->0; 0: saturate at 0 / max
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  en         in   1      count enable; advances prescaler while high
//  up         in   1      direction: 1 = increment, 0 = decrement (sampled on step cycle)
//  load       in   1      parallel load strobe
//  load_gray  in   WIDTH  Gray value to load
//  gray       out  WIDTH  registered Gray-coded count (to decode stage)
//  step       out  1      1-cycle pulse, high in the cycle gray shows a new stepped value
//  tc         out  1      1-cycle terminal-count pulse (see BEHAVIOUR)
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Internal state: binary count cnt[WIDTH], prescaler presc (0..TICK_DIV-1).
//    gray is a register loaded with bin2gray(next cnt); never combinational from cnt.
//  - Priority per edge: rst > load > step > hold.
//  - rst=1: cnt=0, presc=0, gray=0, step=0, tc=0 on next edge; mid-operation reset
//    discards any pending prescale count and any simultaneous load.
//  - load=1: cnt=gray2bin(load_gray), gray=load_gray, presc=0, step=0, tc=0 next edge;
//    en ignored that cycle.
//  - en=1, no load: tick = (presc==TICK_DIV-1); presc = tick ? 0 : presc+1.
//    en=0: presc, cnt, gray hold; step=0, tc=0.
//  - On tick: up=1 -> cnt+1, up=0 -> cnt-1. Latency 1: gray, step valid after the edge.
//  - Boundary, WRAP=1: max+1 -> 0, 0-1 -> max; tc=1 with step=1 in that cycle.
//  - Boundary, WRAP=0: step toward the limit while at the limit is refused: cnt, gray
//    hold, step=0, tc=1 (one pulse per refused tick).
//  - Non-boundary steps: tc=0. Direction change between ticks is legal; only up at
//    tick cycle matters. presc is not reset by direction change.
//  - Invariant: whenever step=1, gray differs from its previous value in exactly one bit.
//  - step/tc are registered pulses, low in every cycle without a tick or refused tick.
// STRUCTURE
//  - gray_pkg: functions bin2gray(b)=b^(b>>1) and gray2bin (prefix XOR from MSB),
//    parameterised on width; shared with the decode stage.
//  - One sub-module: gray_tick_gen (en, rst -> tick) holding the prescaler;
//    TICK_DIV=1 reduces it to tick=en. Counter/boundary logic lives in top.
// TESTING
//  1 WIDTH=4,TICK_DIV=1,WRAP=1, rst then en=1,up=1: gray 0000,0001,0011,0010,0110,...,
//    1000,0000; tc=1 only on the 1000->0000 step; step=1 every cycle.
//  2 From reset, en=1,up=0 for 1 cycle: gray=1000 (bin 15), step=1, tc=1.
//  3 load=1,load_gray=1100,en=1 same cycle: next gray=1100, step=0; next up step
//    -> 1101 (bin 9), step=1, tc=0.
//  4 TICK_DIV=3, en high 7 cycles with a 2-cycle en gap after cycle 2: steps on en
//    cycles 3 and 6 only; gray holds through gap; presc resumes, not cleared.
//  5 WRAP=0, load 1000 (max), en=1,up=1 3 ticks: gray stays 1000, step=0, tc=1 each tick;
//    up=0 next tick -> 1001, tc=0.
//  6 rst asserted with load=1 and tick pending mid-run: next gray=0000, step=0, tc=0;
//    checker asserts Hamming distance 1 on every step across all runs.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg: Gray/binary conversion helpers shared by the counter and the decode stage.
// Words are zero-extended to GRAY_MAXW bits; callers truncate results to their own width.
package gray_pkg;
  localparam int GRAY_MAXW = 32;
  typedef logic [GRAY_MAXW-1:0] gword_t;
  function automatic gword_t bin2gray(input gword_t b);
    return b ^ (b >> 1);
  endfunction
  // Prefix XOR from the MSB down; zero-extension keeps narrow words correct.
  function automatic gword_t gray2bin(input gword_t g);
    gword_t b;
    b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
    for (int i = GRAY_MAXW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_tick_gen.sv
// gray_tick_gen: enable prescaler, one tick per TICK_DIV en-high cycles.
// With TICK_DIV=1 the counter stays at zero and the tick follows en directly.
module gray_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  logic [PW-1:0] r_presc;
  assign o_tick = i_en && (r_presc == LAST);
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_presc <= '0;
    else if (i_en) r_presc <= o_tick ? '0 : r_presc + 1'b1;
  end
endmodule

// File: rtl/gray_step_counter.sv
// gray_step_counter: prescaled up/down Gray counter with load, wrap/saturate and terminal count.
// The binary count drives arithmetic; gray is a separate register loaded with the next code.
module gray_step_counter
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 1,
  parameter bit WRAP     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray,
  output logic             step,
  output logic             tc
);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic [WIDTH-1:0] r_cnt, r_gray, w_nxt;
  logic             r_step, r_tc, w_tick, w_lim, w_refuse;
  gray_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (en),
    .i_clr  (load),
    .o_tick (w_tick)
  );
  assign w_nxt    = up ? r_cnt + 1'b1 : r_cnt - 1'b1;
  assign w_lim    = up ? (r_cnt == MAX) : (r_cnt == '0);
  assign w_refuse = (WRAP == 1'b0) && w_lim;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_gray <= '0;
      r_step <= 1'b0;
      r_tc   <= 1'b0;
    end else if (load) begin
      r_cnt  <= WIDTH'(gray2bin(gword_t'(load_gray)));
      r_gray <= load_gray;
      r_step <= 1'b0;
      r_tc   <= 1'b0;
    end else if (w_tick) begin
      // A refused saturating step still reports tc so upstream sees the limit.
      r_step <= !w_refuse;
      r_tc   <= w_lim;
      if (!w_refuse) begin
        r_cnt  <= w_nxt;
        r_gray <= WIDTH'(bin2gray(gword_t'(w_nxt)));
      end
    end else begin
      r_step <= 1'b0;
      r_tc   <= 1'b0;
    end
  end
  assign gray = r_gray;
  assign step = r_step;
  assign tc   = r_tc;
endmodule

// File: tb/tb_gray_step_counter.sv
// tb_gray_step_counter: three configurations driven in lockstep against an integer reference model.
module tb_gray_step_counter;
  localparam int N = 3;
  localparam int TD[N] = '{1, 3, 1};
  localparam bit WR[N] = '{1'b1, 1'b1, 1'b0};
  logic clk = 1'b0;
  logic rst, en, up, load;
  logic [3:0] load_gray;
  logic [3:0] g[N];
  logic s[N], t[N];
  int mv[N], mp[N], eg[N], es[N], et[N];
  logic [3:0] pg[N];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < N; k++) begin : g_dut
    gray_step_counter #(.WIDTH(4), .TICK_DIV(TD[k]), .WRAP(WR[k])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .up        (up),
      .load      (load),
      .load_gray (load_gray),
      .gray      (g[k]),
      .step      (s[k]),
      .tc        (t[k])
    );
  end
  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  function automatic int to_gray(input int v);
    return v ^ (v >> 1);
  endfunction
  function automatic int from_gray(input int code);
    int r = 0;
    for (int c = 0; c < 16; c++) if (to_gray(c) == code) r = c;
    return r;
  endfunction
  // Reference: integer count, prescale counter and the wrap/saturate rules as arithmetic.
  task automatic model(input int k);
    int target;
    bit tick;
    es[k] = 0;
    et[k] = 0;
    if (rst) begin
      mv[k] = 0;
      mp[k] = 0;
    end else if (load) begin
      mv[k] = from_gray(int'(load_gray));
      mp[k] = 0;
    end else if (en) begin
      tick  = (mp[k] + 1 == TD[k]);
      mp[k] = tick ? 0 : mp[k] + 1;
      if (tick) begin
        target = up ? mv[k] + 1 : mv[k] - 1;
        if (target < 0 || target > 15) begin
          et[k] = 1;
          if (WR[k]) begin
            mv[k] = (target + 16) % 16;
            es[k] = 1;
          end
        end else begin
          mv[k] = target;
          es[k] = 1;
        end
      end
    end
    eg[k] = to_gray(mv[k]);
  endtask
  task automatic cyc(input bit r, input bit e, input bit u, input bit l, input logic [3:0] lg);
    rst = r; en = e; up = u; load = l; load_gray = lg;
    for (int k = 0; k < N; k++) begin
      pg[k] = g[k];
      model(k);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("gray[%0d]", k), int'(g[k]), eg[k]);
      check($sformatf("step[%0d]", k), int'(s[k]), es[k]);
      check($sformatf("tc[%0d]", k), int'(t[k]), et[k]);
      if (s[k]) check($sformatf("hamming[%0d]", k), $countones(g[k] ^ pg[k]), 1);
    end
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_gray = '0;
    for (int k = 0; k < N; k++) begin mv[k] = 0; mp[k] = 0; end
    cyc(1, 0, 0, 0, 4'h0);
    check("reset_gray", int'(g[0]), 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 1, 0, 4'h0);
    check("wrap_up_gray", int'(g[0]), 0);
    check("wrap_up_tc", int'(t[0]), 1);
    cyc(1, 0, 0, 0, 4'h0);
    cyc(0, 1, 0, 0, 4'h0);
    check("wrap_down_gray", int'(g[0]), 8);
    check("wrap_down_tc", int'(t[0]), 1);
    check("sat_zero_step", int'(s[2]), 0);
    cyc(0, 1, 1, 1, 4'b1100);
    check("load_gray", int'(g[0]), 12);
    check("load_step", int'(s[0]), 0);
    cyc(0, 1, 1, 0, 4'h0);
    check("after_load_gray", int'(g[0]), 13);
    cyc(0, 0, 1, 1, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 4'h0);
      check("sat_hold_gray", int'(g[2]), 8);
      check("sat_refuse_tc", int'(t[2]), 1);
    end
    cyc(0, 1, 0, 0, 4'h0);
    check("sat_release_gray", int'(g[2]), 9);
    cyc(1, 0, 0, 0, 4'h0);
    cyc(0, 1, 1, 0, 4'h0);
    cyc(0, 1, 1, 0, 4'h0);
    cyc(0, 0, 1, 0, 4'h0);
    cyc(0, 0, 1, 0, 4'h0);
    cyc(0, 1, 1, 0, 4'h0);
    check("presc_resume_step", int'(s[1]), 1);
    cyc(0, 1, 1, 0, 4'h0);
    cyc(0, 1, 0, 0, 4'h0);
    cyc(1, 1, 1, 1, 4'b0110);
    check("rst_over_load", int'(g[1]), 0);
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(63) == 0, $urandom_range(3) != 0, 1'($urandom_range(1)),
          $urandom_range(15) == 0, 4'($urandom_range(15)));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
